// File: rtl/alu_iter.sv
// Bit-serial (slice-serial) Hack-style ALU: SLICE bits per clock, LSB first.
// Ports: clk, rst_n, in_valid/in_ready, x, y, ctrl, out_valid/out_ready,
//        out, zr, ng; cout/ovf only when ALU_ITER_FLAGS_EN is defined.
module alu_iter #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
`ifdef ALU_ITER_FLAGS_EN
  output logic             cout,
  output logic             ovf,
`endif
  output logic             ng
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] x_q, y_q, out_q;
  logic [5:0]       ctrl_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q, acc_q, zr_q, ng_q;

  logic accept, last;

  assign accept = in_valid && in_ready;
  assign last   = (idx_q == IW'(NSLICE - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (last)   state_d = DONE;
      DONE: begin
        if (out_ready) state_d = in_valid ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state_q == IDLE) ||
                ((state_q == DONE) && out_ready);
    out_valid = (state_q == DONE);
  end

  // Slice datapath: operands shift right so the active slice is always
  // at the bottom; results shift in from the top so slice 0 lands at LSB.
  logic              zx, nx, zy, ny, fn, no;
  logic [SLICE-1:0]  xs, ys, r;
  logic [SLICE:0]    sum;
  logic [WIDTH+SLICE-1:0] cat;
  logic [WIDTH-1:0]  out_nx;
  logic              carry_nx, acc_nx;

  assign {zx, nx, zy, ny, fn, no} = ctrl_q;

  always_comb begin
    xs = zx ? '0 : x_q[SLICE-1:0];
    xs = nx ? ~xs : xs;
    ys = zy ? '0 : y_q[SLICE-1:0];
    ys = ny ? ~ys : ys;
    sum = {1'b0, xs} + {1'b0, ys} + {{SLICE{1'b0}}, carry_q};
    r   = fn ? sum[SLICE-1:0] : (xs & ys);
    r   = no ? ~r : r;
    carry_nx = fn ? sum[SLICE] : carry_q;
    acc_nx   = acc_q && (r == '0);
  end

  assign cat    = {r, out_q};
  assign out_nx = cat[WIDTH+SLICE-1:SLICE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      ctrl_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= 1'b0;
      out_q   <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
    end else if (accept) begin
      x_q     <= x;
      y_q     <= y;
      ctrl_q  <= ctrl;
      idx_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= 1'b1;
    end else if (state_q == RUN) begin
      x_q     <= x_q >> SLICE;
      y_q     <= y_q >> SLICE;
      out_q   <= out_nx;
      carry_q <= carry_nx;
      acc_q   <= acc_nx;
      idx_q   <= idx_q + IW'(1);
      if (last) begin
        zr_q <= acc_nx;
        ng_q <= r[SLICE-1];
      end
    end
  end

  assign out = out_q;
  assign zr  = zr_q;
  assign ng  = ng_q;

`ifdef ALU_ITER_FLAGS_EN
  logic cout_q, ovf_q;
  logic cin_msb;

  // Carry into the top bit recovered from the sum bit itself.
  assign cin_msb = xs[SLICE-1] ^ ys[SLICE-1] ^ sum[SLICE-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state_q == RUN && last && !accept) begin
      cout_q <= fn && sum[SLICE];
      ovf_q  <= fn && (cin_msb ^ sum[SLICE]);
    end
  end

  assign cout = cout_q;
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_alu_iter.sv
// Directed-vector bench for alu_iter.
// Table of ops, then backpressure, back-to-back and mid-RUN reset sequences.
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x, y;
  logic [5:0]  ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_w;
  logic        zr, ng;
`ifdef ALU_ITER_FLAGS_EN
  logic        cout, ovf;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_w),
    .zr        (zr),
`ifdef ALU_ITER_FLAGS_EN
    .cout      (cout),
    .ovf       (ovf),
`endif
    .ng        (ng)
  );

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [5:0]  c;
    logic [15:0] eo;
    logic        ezr;
    logic        eng;
    logic        ecout;
    logic        eovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one op, handshake on the next edge, count edges to out_valid.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [5:0] c, output int lat);
    @(negedge clk);
    x = a; y = b; ctrl = c; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = 16'hDEAD; y = 16'hBEEF; ctrl = 6'b111111;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic check_res(input string tag, input vec_t v);
    chk({tag, "_out"}, {16'd0, out_w}, {16'd0, v.eo});
    chk({tag, "_zr"}, {31'd0, zr}, {31'd0, v.ezr});
    chk({tag, "_ng"}, {31'd0, ng}, {31'd0, v.eng});
`ifdef ALU_ITER_FLAGS_EN
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, v.ecout});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, v.eovf});
`endif
  endtask

  initial begin
    int lat;
    logic [15:0] held;
    logic        hzr, hng;

    vecs[0] = '{16'h1234, 16'h0FFF, 6'b000010, 16'h2233, 0, 0, 0, 0};
    vecs[1] = '{16'h0005, 16'h0007, 6'b010011, 16'hFFFE, 0, 1, 1, 0};
    vecs[2] = '{16'hABCD, 16'h1234, 6'b101010, 16'h0000, 1, 0, 0, 0};
    vecs[3] = '{16'hF0F0, 16'h3C3C, 6'b000000, 16'h3030, 0, 0, 0, 0};
    vecs[4] = '{16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 0, 1, 0, 1};
    vecs[5] = '{16'h5555, 16'hAAAA, 6'b111010, 16'hFFFF, 0, 1, 0, 0};
    vecs[6] = '{16'hFFFF, 16'h1234, 6'b011111, 16'h0000, 1, 0, 0, 0};
    vecs[7] = '{16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 1, 0, 1, 0};
    vecs[8] = '{16'h8000, 16'h8000, 6'b000010, 16'h0000, 1, 0, 1, 1};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = '0; y = '0; ctrl = '0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", {16'd0, out_w}, 32'd0);
    chk("rst_zr", {31'd0, zr}, 32'd0);
    chk("rst_ng", {31'd0, ng}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].x, vecs[i].y, vecs[i].c, lat);
      chk($sformatf("v%0d_latency", i), lat, 32'd4);
      check_res($sformatf("v%0d", i), vecs[i]);
      drain();
    end

    // Backpressure, then back-to-back accept from DONE.
    issue(16'h1234, 16'h0FFF, 6'b000010, lat);
    chk("bp_latency", lat, 32'd4);
    held = out_w; hzr = zr; hng = ng;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out", {16'd0, out_w}, 32'h2233);
      chk("bp_stable", {16'd0, out_w, zr, ng, 14'd0},
          {16'd0, held, hzr, hng, 14'd0});
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    x = 16'h0005; y = 16'h0007; ctrl = 6'b010011;
    #1;
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x = 16'hDEAD; y = 16'hBEEF;
    chk("b2b_valid_drop", {31'd0, out_valid}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("b2b_latency", lat, 32'd4);
    check_res("b2b", vecs[1]);
    drain();

    // Reset in the middle of RUN.
    @(negedge clk);
    x = 16'h1234; y = 16'h0FFF; ctrl = 6'b000010; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out", {16'd0, out_w}, 32'd0);
    chk("mid_rst_zr", {31'd0, zr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h0001, 16'h0001, 6'b000010, lat);
    chk("post_rst_latency", lat, 32'd4);
    chk("post_rst_out", {16'd0, out_w}, 32'h0002);
    chk("post_rst_zr", {31'd0, zr}, 32'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
